// File: rtl/cpu_idecode_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_idecode_pkg
// Brief  : Shared RV32I decode constants, the immediate-format enum and the
//          opcode -> format classifier used by the decode stage.
// Rev    : 1.0  initial release
// ============================================================================
package cpu_idecode_pkg;

  // RV32I base opcodes (instr[6:0])
  localparam logic [6:0] c_opc_op       = 7'b0110011;
  localparam logic [6:0] c_opc_op_imm   = 7'b0010011;
  localparam logic [6:0] c_opc_load     = 7'b0000011;
  localparam logic [6:0] c_opc_jalr     = 7'b1100111;
  localparam logic [6:0] c_opc_misc_mem = 7'b0001111;
  localparam logic [6:0] c_opc_system   = 7'b1110011;
  localparam logic [6:0] c_opc_store    = 7'b0100011;
  localparam logic [6:0] c_opc_branch   = 7'b1100011;
  localparam logic [6:0] c_opc_lui      = 7'b0110111;
  localparam logic [6:0] c_opc_auipc    = 7'b0010111;
  localparam logic [6:0] c_opc_jal      = 7'b1101111;

  // Immediate / operand format; FMT_X marks an illegal encoding
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5,
    FMT_X = 3'd6
  } imm_fmt_e;

  // Every base opcode ends in 2'b11, so an exact 7-bit match also rejects
  // compressed / non-32-bit encodings.
  function automatic imm_fmt_e fmt_of(input logic [6:0] opcode);
    imm_fmt_e fmt;
    case (opcode)
      c_opc_op:                                  fmt = FMT_R;
      c_opc_op_imm, c_opc_load, c_opc_jalr,
      c_opc_misc_mem, c_opc_system:              fmt = FMT_I;
      c_opc_store:                               fmt = FMT_S;
      c_opc_branch:                              fmt = FMT_B;
      c_opc_lui, c_opc_auipc:                    fmt = FMT_U;
      c_opc_jal:                                 fmt = FMT_J;
      default:                                   fmt = FMT_X;
    endcase
    return fmt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_idecode_if.sv
`default_nettype none
// ============================================================================
// Module : cpu_idecode_if
// Brief  : Fetch -> decode beat interface (valid/ready handshake).
//          master = fetch side, slave = decode side.
//          f_valid, f_instr, f_pc : beat from fetch
//          d_up_ready             : decode can take a beat (fetch advance)
// Rev    : 1.0  initial release
// ============================================================================
interface cpu_idecode_if #(
  parameter int XLEN = 32
) ();
  logic            f_valid;
  logic [31:0]     f_instr;
  logic [XLEN-1:0] f_pc;
  logic            d_up_ready;

  modport master (output f_valid, f_instr, f_pc, input  d_up_ready);
  modport slave  (input  f_valid, f_instr, f_pc, output d_up_ready);
endinterface
`default_nettype wire

// File: rtl/cpu_idecode_imm_gen.sv
`default_nettype none
// ============================================================================
// Module : cpu_idecode_imm_gen
// Brief  : Combinational RV32I immediate builder.
//          instr_hi : instr[31:7]   fmt : immediate format
//          imm      : sign-extended immediate, 0 for R-type / illegal
// Rev    : 1.0  initial release
// ============================================================================
module cpu_idecode_imm_gen
  import cpu_idecode_pkg::*;
(
  input  logic [31:7] instr_hi,
  input  imm_fmt_e    fmt,
  output logic [31:0] imm
);

  always_comb begin
    imm = 32'd0;
    case (fmt)
      FMT_I: imm = {{20{instr_hi[31]}}, instr_hi[31:20]};
      FMT_S: imm = {{20{instr_hi[31]}}, instr_hi[31:25], instr_hi[11:7]};
      FMT_B: imm = {{19{instr_hi[31]}}, instr_hi[31], instr_hi[7],
                    instr_hi[30:25], instr_hi[11:8], 1'b0};
      FMT_U: imm = {instr_hi[31:12], 12'd0};
      FMT_J: imm = {{11{instr_hi[31]}}, instr_hi[31], instr_hi[19:12],
                    instr_hi[20], instr_hi[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cpu_idecode.sv
`default_nettype none
// ============================================================================
// Module : cpu_idecode
// Brief  : RV32I decode stage. Takes {instr, pc} beats from fetch, splits
//          fields, builds the immediate, flags illegal encodings and presents
//          one registered bundle per instruction to execute. A one-entry skid
//          register (plus the output register) keeps the upstream ready
//          registered when SKID=1.
//   clk, rst_n        : clock / async active-low reset
//   fetch (slave)     : f_valid, f_instr, f_pc in; d_up_ready out
//   flush             : kill held and incoming beats
//   x_ready           : execute takes the bundle when d_valid & x_ready
//   d_*               : registered decode bundle
// Rev    : 1.0  initial release
// ============================================================================
module cpu_idecode
  import cpu_idecode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit SKID = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  cpu_idecode_if.slave    fetch,
  input  logic            flush,
  input  logic            x_ready,
  output logic            d_valid,
  output logic [XLEN-1:0] d_pc,
  output logic [31:0]     d_instr,
  output logic [6:0]      d_opcode,
  output logic [2:0]      d_funct3,
  output logic            d_funct7b5,
  output logic [4:0]      d_rs1,
  output logic [4:0]      d_rs2,
  output logic [4:0]      d_rd,
  output logic [XLEN-1:0] d_imm,
  output logic            d_illegal
);

  logic            r_d_valid;
  logic [XLEN-1:0] r_d_pc;
  logic [31:0]     r_d_instr;
  logic [4:0]      r_rs1, r_rs2, r_rd;
  logic [XLEN-1:0] r_imm;
  logic            r_illegal;

  logic            w_up_ready;
  logic            w_skid_valid;
  logic [31:0]     w_skid_instr;
  logic [XLEN-1:0] w_skid_pc;

  logic            w_accept;
  logic            w_out_load;
  logic            w_src_valid;
  logic [31:0]     w_src_instr;
  logic [XLEN-1:0] w_src_pc;
  imm_fmt_e        w_fmt;
  logic [31:0]     w_imm;

  assign w_accept   = fetch.f_valid & w_up_ready;
  assign w_out_load = !r_d_valid | x_ready;

  // A held skid beat is older than anything on the fetch bus, so it wins.
  assign w_src_valid = w_skid_valid | w_accept;
  assign w_src_instr = w_skid_valid ? w_skid_instr : fetch.f_instr;
  assign w_src_pc    = w_skid_valid ? w_skid_pc    : fetch.f_pc;

  generate
    if (SKID) begin : g_skid
      logic            r_skid_valid;
      logic [31:0]     r_skid_instr;
      logic [XLEN-1:0] r_skid_pc;
      logic            r_up_ready;

      // Ready is simply "skid will be empty next cycle", computed registered.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_skid_valid <= 1'b0;
          r_skid_instr <= 32'd0;
          r_skid_pc    <= '0;
          r_up_ready   <= 1'b1;
        end else if (flush) begin
          r_skid_valid <= 1'b0;
          r_up_ready   <= 1'b1;
        end else if (w_out_load && r_skid_valid) begin
          r_skid_valid <= 1'b0;
          r_up_ready   <= 1'b1;
        end else if (!w_out_load && w_accept) begin
          r_skid_valid <= 1'b1;
          r_skid_instr <= fetch.f_instr;
          r_skid_pc    <= fetch.f_pc;
          r_up_ready   <= 1'b0;
        end
      end

      assign w_skid_valid = r_skid_valid;
      assign w_skid_instr = r_skid_instr;
      assign w_skid_pc    = r_skid_pc;
      assign w_up_ready   = r_up_ready;
    end else begin : g_no_skid
      assign w_skid_valid = 1'b0;
      assign w_skid_instr = 32'd0;
      assign w_skid_pc    = '0;
      assign w_up_ready   = !r_d_valid | x_ready;
    end
  endgenerate

  assign fetch.d_up_ready = w_up_ready;

  // Format decode on the selected source beat
  assign w_fmt = fmt_of(w_src_instr[6:0]);

  cpu_idecode_imm_gen u_imm_gen (
    .instr_hi (w_src_instr[31:7]),
    .fmt      (w_fmt),
    .imm      (w_imm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d_valid <= 1'b0;
      r_d_pc    <= '0;
      r_d_instr <= 32'd0;
      r_rs1     <= 5'd0;
      r_rs2     <= 5'd0;
      r_rd      <= 5'd0;
      r_imm     <= '0;
      r_illegal <= 1'b0;
    end else if (flush) begin
      r_d_valid <= 1'b0;
    end else if (w_out_load) begin
      r_d_valid <= w_src_valid;
      if (w_src_valid) begin
        r_d_pc    <= w_src_pc;
        r_d_instr <= w_src_instr;
        r_rd      <= (w_fmt inside {FMT_S, FMT_B, FMT_X}) ? 5'd0 : w_src_instr[11:7];
        r_rs1     <= (w_fmt inside {FMT_U, FMT_J, FMT_X}) ? 5'd0 : w_src_instr[19:15];
        r_rs2     <= (w_fmt inside {FMT_R, FMT_S, FMT_B}) ? w_src_instr[24:20] : 5'd0;
        r_imm     <= XLEN'(w_imm);
        r_illegal <= (w_fmt == FMT_X);
      end
    end
  end

  assign d_valid    = r_d_valid;
  assign d_pc       = r_d_pc;
  assign d_instr    = r_d_instr;
  assign d_opcode   = r_d_instr[6:0];
  assign d_funct3   = r_d_instr[14:12];
  assign d_funct7b5 = r_d_instr[30];
  assign d_rs1      = r_rs1;
  assign d_rs2      = r_rs2;
  assign d_rd       = r_rd;
  assign d_imm      = r_imm;
  assign d_illegal  = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_cpu_idecode.sv
`default_nettype none
// ============================================================================
// Module : tb_cpu_idecode
// Brief  : Directed self-checking bench for cpu_idecode (SKID=1).
// Rev    : 1.0  initial release
// ============================================================================
module tb_cpu_idecode;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        x_ready;
  logic        d_valid;
  logic [31:0] d_pc;
  logic [31:0] d_instr;
  logic [6:0]  d_opcode;
  logic [2:0]  d_funct3;
  logic        d_funct7b5;
  logic [4:0]  d_rs1, d_rs2, d_rd;
  logic [31:0] d_imm;
  logic        d_illegal;

  int n_checks = 0;
  int n_pass   = 0;

  cpu_idecode_if #(.XLEN(32)) fif ();

  cpu_idecode #(.XLEN(32), .SKID(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch      (fif),
    .flush      (flush),
    .x_ready    (x_ready),
    .d_valid    (d_valid),
    .d_pc       (d_pc),
    .d_instr    (d_instr),
    .d_opcode   (d_opcode),
    .d_funct3   (d_funct3),
    .d_funct7b5 (d_funct7b5),
    .d_rs1      (d_rs1),
    .d_rs2      (d_rs2),
    .d_rd       (d_rd),
    .d_imm      (d_imm),
    .d_illegal  (d_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    fif.f_valid = 1'b1;
    fif.f_instr = instr;
    fif.f_pc    = pc;
    x_ready     = 1'b1;
    tick();
    fif.f_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; x_ready = 1'b1;
    fif.f_valid = 1'b0; fif.f_instr = 32'd0; fif.f_pc = 32'd0;
    tick(); tick();
    chk("rst_valid", {31'd0, d_valid}, 32'd0);
    chk("rst_ready", {31'd0, fif.d_up_ready}, 32'd1);
    chk("rst_imm", d_imm, 32'd0);
    chk("rst_pc", d_pc, 32'd0);
    rst_n = 1'b1;
    tick();

    // addi x1,x2,-1
    send(32'hFFF10093, 32'h100);
    chk("addi_valid", {31'd0, d_valid}, 32'd1);
    chk("addi_imm", d_imm, 32'hFFFFFFFF);
    chk("addi_rd", {27'd0, d_rd}, 32'd1);
    chk("addi_rs1", {27'd0, d_rs1}, 32'd2);
    chk("addi_rs2", {27'd0, d_rs2}, 32'd0);
    chk("addi_ill", {31'd0, d_illegal}, 32'd0);
    chk("addi_pc", d_pc, 32'h100);

    // sw x5,8(x2)
    send(32'h00512423, 32'h104);
    chk("sw_imm", d_imm, 32'h8);
    chk("sw_rs1", {27'd0, d_rs1}, 32'd2);
    chk("sw_rs2", {27'd0, d_rs2}, 32'd5);
    chk("sw_rd", {27'd0, d_rd}, 32'd0);
    chk("sw_f3", {29'd0, d_funct3}, 32'd2);

    // beq x0,x0,-4
    send(32'hFE000EE3, 32'h108);
    chk("beq_imm", d_imm, 32'hFFFFFFFC);
    chk("beq_rd", {27'd0, d_rd}, 32'd0);

    // lui x3,0x12345
    send(32'h123451B7, 32'h10C);
    chk("lui_imm", d_imm, 32'h12345000);
    chk("lui_rs1", {27'd0, d_rs1}, 32'd0);
    chk("lui_rd", {27'd0, d_rd}, 32'd3);

    // jal x1,+2048
    send(32'h001000EF, 32'h110);
    chk("jal_imm", d_imm, 32'h800);
    chk("jal_rd", {27'd0, d_rd}, 32'd1);
    chk("jal_opc", {25'd0, d_opcode}, 32'h6F);

    // sub x3,x1,x2
    send(32'h402081B3, 32'h114);
    chk("sub_imm", d_imm, 32'd0);
    chk("sub_rs2", {27'd0, d_rs2}, 32'd2);
    chk("sub_rs1", {27'd0, d_rs1}, 32'd1);
    chk("sub_f7b5", {31'd0, d_funct7b5}, 32'd1);

    // illegal encodings
    send(32'h00000000, 32'h118);
    chk("ill0_flag", {31'd0, d_illegal}, 32'd1);
    chk("ill0_imm", d_imm, 32'd0);
    chk("ill0_valid", {31'd0, d_valid}, 32'd1);
    send(32'hFFFFFFFF, 32'h11C);
    chk("ill1_flag", {31'd0, d_illegal}, 32'd1);
    chk("ill1_imm", d_imm, 32'd0);
    chk("ill1_rs1", {27'd0, d_rs1}, 32'd0);
    chk("ill1_rd", {27'd0, d_rd}, 32'd0);
    tick();
    chk("idle_valid", {31'd0, d_valid}, 32'd0);

    // Stream pc 0,4,8,C with a 3-cycle execute stall after the first beat
    fif.f_valid = 1'b1; fif.f_instr = 32'h00000013; fif.f_pc = 32'h0; x_ready = 1'b1;
    tick();
    chk("st_pc0", d_pc, 32'h0);
    fif.f_pc = 32'h4; x_ready = 1'b0;
    tick();                                  // pc4 captured into the skid
    chk("st_hold_pc", d_pc, 32'h0);
    chk("st_rdy_low", {31'd0, fif.d_up_ready}, 32'd0);
    fif.f_pc = 32'h8;
    tick();
    chk("st_hold2", d_pc, 32'h0);
    chk("st_rdy_low2", {31'd0, fif.d_up_ready}, 32'd0);
    tick();
    x_ready = 1'b1;
    tick();
    chk("st_pc4", d_pc, 32'h4);
    chk("st_rdy_back", {31'd0, fif.d_up_ready}, 32'd1);
    tick();
    chk("st_pc8", d_pc, 32'h8);
    fif.f_pc = 32'hC;
    tick();
    chk("st_pcC", d_pc, 32'hC);
    fif.f_valid = 1'b0;
    tick();
    chk("st_drain", {31'd0, d_valid}, 32'd0);

    // Flush with the skid full and a beat on the bus
    fif.f_valid = 1'b1; fif.f_pc = 32'h20; x_ready = 1'b0;
    tick();
    fif.f_pc = 32'h24;
    tick();
    chk("fl_full", {31'd0, fif.d_up_ready}, 32'd0);
    flush = 1'b1; fif.f_pc = 32'h28; x_ready = 1'b1;
    tick();
    chk("fl_valid", {31'd0, d_valid}, 32'd0);
    chk("fl_ready", {31'd0, fif.d_up_ready}, 32'd1);
    flush = 1'b0; fif.f_pc = 32'h40;
    tick();
    chk("fl_next_v", {31'd0, d_valid}, 32'd1);
    chk("fl_next_pc", d_pc, 32'h40);
    fif.f_valid = 1'b0;
    tick();
    chk("fl_no_stale", {31'd0, d_valid}, 32'd0);

    // Asynchronous reset mid-stream with the skid full
    fif.f_valid = 1'b1; fif.f_pc = 32'h60; x_ready = 1'b0;
    tick();
    fif.f_pc = 32'h64;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, d_valid}, 32'd0);
    chk("arst_ready", {31'd0, fif.d_up_ready}, 32'd1);
    fif.f_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_idle", {31'd0, d_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
